// File: rtl/fetch_mem_arb.sv
// fetch_mem_arb: arbitrates instruction fetch and data accesses onto one single-port memory,
// with fetch anti-starvation, flush-drop of in-flight fetches and a sticky response timeout.
module fetch_mem_arb #(
    parameter int TIMEOUT = 64,
    parameter int STARVE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;
    state_t      state, state_nx;
    logic [6:0]  timer;
    logic [7:0]  starve_cnt;
    logic        drop;
    logic        busy, tmo, fin, gnt_if, gnt_d;
    always_comb begin
        busy     = state != IDLE;
        tmo      = busy && !mem_valid && (timer == 7'(TIMEOUT - 1));
        fin      = busy && (mem_valid || tmo);
        gnt_if   = state == IDLE && if_req && (!d_req || starve_cnt == 8'(STARVE));
        gnt_d    = state == IDLE && d_req && !gnt_if;
        // a flush in the completion cycle itself must also swallow the fetch
        if_done  = state == IF_BUSY && fin && !(drop || if_flush);
        if_rdata = if_done ? (mem_valid ? mem_rdata : 16'hF000) : '0;
        d_done   = state == D_BUSY && fin;
        d_rdata  = (d_done && mem_valid && !mem_wr) ? mem_rdata : '0;
        state_nx = state;
        state_nx = fin ? IDLE : gnt_if ? IF_BUSY : gnt_d ? D_BUSY : state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            timer      <= '0;
            starve_cnt <= '0;
            drop       <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_en <= gnt_if || gnt_d;
            if (gnt_if || gnt_d) begin
                mem_wr    <= gnt_d && d_wr;
                mem_addr  <= gnt_d ? d_addr : if_addr;
                mem_wdata <= gnt_d ? d_wdata : '0;
            end
            timer <= (busy && !fin) ? timer + 7'd1 : '0;
            if (gnt_if)
                starve_cnt <= '0;
            else if (gnt_d && if_req && starve_cnt != 8'(STARVE))
                starve_cnt <= starve_cnt + 8'd1;
            drop <= state == IF_BUSY && !fin && (drop || if_flush);
            err  <= err || tmo;
        end
    end
endmodule

// File: tb/tb_fetch_mem_arb.sv
// tb_fetch_mem_arb: directed scoreboard bench; stimulus pushes expected completions,
// a negedge monitor pops and compares them as the DUT reports done.
module tb_fetch_mem_arb;
    logic        clk = 0, rst = 1;
    logic        if_req = 0, if_flush = 0, if_done;
    logic [15:0] if_addr = 0, if_rdata;
    logic        d_req = 0, d_wr = 0, d_done;
    logic [15:0] d_addr = 0, d_wdata = 0, d_rdata;
    logic        mem_en, mem_wr, mem_valid = 0, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata = 0;

    fetch_mem_arb dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata), .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {bit is_d; logic [15:0] rd;} exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, req_cyc = 0, n_if = 0;
    int if_left = 0, d_left = 0, d_idx = 0, lat = 1;
    logic [15:0] if_a = 0;
    logic        dt_wr [8];
    logic [15:0] dt_addr [8];
    logic [15:0] dt_wdata [8];
    logic [15:0] mem_img [logic [15:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_d, input logic [15:0] rd);
        exp_t e;
        e.is_d = is_d;
        e.rd = rd;
        sb.push_back(e);
    endtask

    function automatic bit cond(input int k);
        case (k)
            0: return mem_en;
            1: return if_done;
            3: return mem_valid;
            default: return sb.size() == 0 && if_left == 0 && d_left == 0;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cond(k) && n < 200);
        chk({nm, " seen"}, 32'(cond(k)), 32'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // requesters: hold each request until its done has been observed
    initial forever begin
        @(posedge clk);
        #1;
        if (if_left > 0 && !if_req) req_cyc = cyc;
        if_req  = if_left > 0;
        if_addr = if_a;
        d_req   = d_left > 0;
        d_wr    = dt_wr[d_idx];
        d_addr  = dt_addr[d_idx];
        d_wdata = dt_wdata[d_idx];
    end

    // memory: mem_valid L cycles after mem_en; lat==0 never answers
    initial begin
        int cnt = 0;
        bit pend = 0;
        logic [15:0] rsp = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 0;
            mem_rdata = 0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_valid = 1;
                    mem_rdata = rsp;
                    pend = 0;
                end
            end
            if (mem_en && lat != 0) begin
                pend = 1;
                cnt = lat;
                rsp = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 16'hDEAD;
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!if_done) chk("if_rdata idle", 32'(if_rdata), 32'h0);
        if (!d_done) chk("d_rdata idle", 32'(d_rdata), 32'h0);
        if (if_done || d_done) begin
            chk("single done", 32'(if_done && d_done), 32'h0);
            if (sb.size() == 0) begin
                chk("unexpected done", 32'(d_done), 32'(if_done));
                chk("unexpected done pending", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("done owner is_d", 32'(d_done), 32'(e.is_d));
                chk("done rdata", 32'(d_done ? d_rdata : if_rdata), 32'(e.rd));
            end
        end
        if (if_done) begin
            n_if++;
            if (if_left > 0) if_left--;
        end
        if (d_done) begin
            if (d_left > 0) d_left--;
            d_idx++;
        end
    end

    initial begin
        dt_wr[0] = 1; dt_addr[0] = 16'h0040; dt_wdata[0] = 16'h5555;
        for (int i = 1; i < 6; i++) begin
            dt_wr[i] = 0; dt_addr[i] = 16'h0200 + 16'(i - 1); dt_wdata[i] = 0;
        end
        dt_wr[6] = 1; dt_addr[6] = 16'h0600; dt_wdata[6] = 16'h9999;
        dt_wr[7] = 0; dt_addr[7] = 0; dt_wdata[7] = 0;
        mem_img[16'h0010] = 16'hA123;
        mem_img[16'h0100] = 16'h1234;
        mem_img[16'h0200] = 16'h1111;
        mem_img[16'h0201] = 16'h2222;
        mem_img[16'h0202] = 16'h3333;
        mem_img[16'h0203] = 16'h4444;
        mem_img[16'h0204] = 16'h5555;
        mem_img[16'h0300] = 16'hBEEF;
        mem_img[16'h0400] = 16'h7777;
        mem_img[16'h0500] = 16'h0BAD;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset mem_en", 32'(mem_en), 0);
        chk("reset mem_addr", 32'(mem_addr), 0);
        chk("reset err", 32'(err), 0);

        // single fetch, L=3
        lat = 3; if_a = 16'h0010; push(0, 16'hA123); if_left = 1;
        wait_for("t1 mem_en", 0);
        chk("t1 mem_en cycle", 32'(cyc - req_cyc), 1);
        chk("t1 mem_addr", 32'(mem_addr), 32'h0010);
        chk("t1 mem_wr", 32'(mem_wr), 0);
        wait_for("t1 if_done", 1);
        chk("t1 done cycle", 32'(cyc - req_cyc), 4);
        wait_for("t1 drain", 4);

        // simultaneous fetch and store: data wins
        lat = 2; if_a = 16'h0100; push(1, 16'h0000); push(0, 16'h1234);
        if_left = 1; d_left = 1;
        wait_for("t2 mem_en", 0);
        chk("t2 mem_wr", 32'(mem_wr), 1);
        chk("t2 mem_addr", 32'(mem_addr), 32'h0040);
        chk("t2 mem_wdata", 32'(mem_wdata), 32'h5555);
        wait_for("t2 drain", 4);

        // starvation: 4 data grants, then the fetch, then the last load
        lat = 1; if_a = 16'h0300;
        push(1, 16'h1111); push(1, 16'h2222); push(1, 16'h3333); push(1, 16'h4444);
        push(0, 16'hBEEF); push(1, 16'h5555);
        if_left = 1; d_left = 5;
        wait_for("t3 drain", 4);

        // flush drops the in-flight fetch; held request refetches
        lat = 4; if_a = 16'h0400; n_if = 0; push(0, 16'h7777); if_left = 1;
        wait_for("t4 mem_en", 0);
        @(posedge clk); #1 if_flush = 1;
        @(posedge clk); #1 if_flush = 0;
        wait_for("t4 if_done", 1);
        chk("t4 done cycle", 32'(cyc - req_cyc), 11);
        wait_for("t4 drain", 4);
        repeat (3) @(negedge clk);
        chk("t4 if_done count", 32'(n_if), 1);

        // timeout: memory never answers
        chk("t5 err before", 32'(err), 0);
        lat = 0; if_a = 16'h0500; push(0, 16'hF000); if_left = 1;
        wait_for("t5 if_done", 1);
        chk("t5 done cycle", 32'(cyc - req_cyc), 64);
        chk("t5 err at abort", 32'(err), 0);
        wait_for("t5 drain", 4);
        repeat (5) @(negedge clk);
        chk("t5 err sticky", 32'(err), 1);

        // reset in D_BUSY, late mem_valid ignored
        lat = 5; d_left = 1;
        wait_for("t6 mem_en", 0);
        #2 rst = 1; d_left = 0; d_req = 0;
        @(negedge clk);
        chk("t6 rst mem_en", 32'(mem_en), 0);
        chk("t6 rst mem_wr", 32'(mem_wr), 0);
        chk("t6 rst mem_addr", 32'(mem_addr), 0);
        chk("t6 rst mem_wdata", 32'(mem_wdata), 0);
        chk("t6 rst err", 32'(err), 0);
        @(posedge clk); #1 rst = 0;
        wait_for("t6 late mem_valid", 3);
        chk("t6 d_done", 32'(d_done), 0);
        chk("t6 if_done", 32'(if_done), 0);
        chk("t6 err", 32'(err), 0);
        repeat (3) @(negedge clk);
        chk("t6 mem_en", 32'(mem_en), 0);
        chk("scoreboard empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_mem_arb.md
FETCH_MEM_ARB -- requirements
Module: fetch_mem_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning max cycles from mem_en to mem_valid before abort.
REQ-002 SHALL have parameter STARVE, default 4, meaning max consecutive data grants while fetch is pending.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_req  in  1  fetch request; held high until if_done.
REQ-006 SHALL have port if_addr  in  16  fetch address (PC); stable while if_req is high.
REQ-007 SHALL have port if_flush  in  1  branch/halt redirect; discards the in-flight fetch.
REQ-008 SHALL have port if_done  out  1  one-cycle fetch completion.
REQ-009 SHALL have port if_rdata  out  16  instruction word; valid only with if_done.
REQ-010 SHALL have port d_req  in  1  data request; held high until d_done.
REQ-011 SHALL have port d_wr  in  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  in  16  data address.
REQ-013 SHALL have port d_wdata  in  16  store data.
REQ-014 SHALL have port d_done  out  1  one-cycle data completion.
REQ-015 SHALL have port d_rdata  out  16  load data; valid only with d_done.
REQ-016 SHALL have port mem_en  out  1  one-cycle request strobe to the single-port memory.
REQ-017 SHALL have ports mem_wr (out, 1), mem_addr (out, 16) and mem_wdata (out, 16), registered and held for the whole transaction.
REQ-018 SHALL have ports mem_valid (in, 1) and mem_rdata (in, 16), the completion pulse and its read data.
REQ-019 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-020 SHALL implement states IDLE, IF_BUSY and D_BUSY, with exactly one memory transaction outstanding at any time.
REQ-021 SHALL, in IDLE at a rising edge, grant d_req over if_req, except when starve_cnt==STARVE, in which case fetch is granted.
REQ-022 SHALL, on grant, register the address, wr and wdata onto the mem_* outputs, enter the BUSY state and assert mem_en only in the first BUSY cycle.
REQ-023 SHALL force mem_wr=0 for fetch transactions.
REQ-024 SHALL, when mem_valid=1 in a BUSY state, combinationally drive the owner's done=1 and rdata=mem_rdata, then return to IDLE at the next edge.
REQ-025 SHALL give a memory of latency L (mem_valid L cycles after mem_en) done in cycle 1+L after the request is first sampled; minimum L is 1.
REQ-026 SHALL drive d_rdata=0 on store completion.
REQ-027 SHALL drive done low and rdata=0 whenever the corresponding done condition is false.
REQ-028 SHALL ignore mem_valid in IDLE.
REQ-029 SHALL set a drop flag when if_flush=1 in IF_BUSY, including the mem_valid cycle itself.
REQ-030 SHALL, with drop set, suppress if_done when the transaction completes, return to IDLE and clear the drop flag.
REQ-031 SHALL treat if_flush in IDLE or D_BUSY as having no effect.
REQ-032 SHALL run a 7-bit timer in BUSY that clears on entry and increments each cycle without mem_valid.
REQ-033 SHALL, at timer==TIMEOUT-1 without mem_valid, set err, pulse the owner's done (if_rdata=16'hF000 halt word, d_rdata=0; fetch done still subject to drop) and go to IDLE.
REQ-034 SHALL keep err set until reset.
REQ-035 SHALL increment starve_cnt on each data grant made while if_req=1, saturating at STARVE.
REQ-036 SHALL clear starve_cnt on any fetch grant.
REQ-037 SHALL grant when a request is raised in the same cycle that done returns the FSM to IDLE (back-to-back transactions have no bubble beyond IDLE).

Reset
REQ-038 SHALL, on rst, immediately clear state to IDLE, mem_en, mem_wr, mem_addr, mem_wdata, timer, starve_cnt, drop and err to 0, with if_done and d_done low.
REQ-039 SHALL, on reset mid-transaction, abandon the transaction with no done pulse; a late mem_valid is ignored (IDLE).

Verification
REQ-040 SHALL cover: if_req, addr 0x0010, L=3, mem_rdata 0xA123 -> mem_en in cycle 1 with mem_addr 0x0010, mem_wr=0; if_done with 0xA123 in cycle 4.
REQ-041 SHALL cover: if_req and d_req (store 0x0040/0x5555) raised together -> data first (mem_wr=1, d_done, d_rdata=0), then the fetch.
REQ-042 SHALL cover: d_req held for 5 back-to-back transactions with if_req high -> 4 data grants, 5th grant to fetch, starve_cnt=0.
REQ-043 SHALL cover: fetch in flight, if_flush pulsed -> no if_done, IDLE after mem_valid, next fetch completes normally.
REQ-044 SHALL cover: memory never responds -> done on the 64th BUSY cycle, if_rdata=0xF000, err=1 held until rst.
REQ-045 SHALL cover: rst asserted in D_BUSY, then mem_valid -> no d_done, all outputs 0.
